// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Ceiling log2. Returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointer and occupancy width: one extra bit so that DEPTH itself is
  // representable and full can be told apart from empty.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered status flags, sticky
// overflow/underflow errors and an optional first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      fifo_Full,
  output logic                      fifo_Empty,
  output logic                      fifo_AlmostFull,
  output logic                      fifo_AlmostEmpty,
  output logic [cnt_w(DEPTH)-1:0]   fifo_Count,
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("sync_fifo_param: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [CW-1:0]     wr_ptr_q;
  logic [CW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_next;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ae_q;
  logic              ovf_q;
  logic              udf_q;
  logic              rd_acc;
  logic              wr_acc;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // Acceptance: a write into a full FIFO is allowed only when a pop frees
  // the slot in the same cycle; a pop from an empty FIFO is always refused.
  always_comb begin
    rd_acc     = rd_en & ~empty_q;
    wr_acc     = wr_en & (~full_q | rd_acc);
    count_next = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
  end

  // Pointers, occupancy and status flags; flags come from count_next so they
  // are exact right after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
      empty_q <= (count_next == '0);
      af_q    <= (count_next >= CW'(AF_LEVEL));
      ae_q    <= (count_next <= CW'(AE_LEVEL));
    end
  end

  // Sticky error bits; a new error event outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (wr_en & ~wr_acc) | (ovf_q & ~err_clr);
      udf_q <= (rd_en & empty_q) | (udf_q & ~err_clr);
    end
  end

  // Registered read port: capture the head on a pop, valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) begin
        rd_data_q <= head_data;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (head_data)
  );

  // In FWFT mode the head word is presented directly and rd_en acts as an ack.
  assign rd_data          = (FWFT != 0) ? head_data : rd_data_q;
  assign rd_valid         = (FWFT != 0) ? ~empty_q  : rd_valid_q;
  assign fifo_Full        = full_q;
  assign fifo_Empty       = empty_q;
  assign fifo_AlmostFull  = af_q;
  assign fifo_AlmostEmpty = ae_q;
  assign fifo_Count       = count_q;
  assign overflow         = ovf_q;
  assign underflow        = udf_q;

endmodule
